// File: rtl/product_bcd_conv.sv
// product_bcd_conv
//   Converts the signed product from the Booth multiplier into sign + packed BCD
//   magnitude using double-dabble (shift-add-3), one product bit per clock.
//   A rising edge of in_valid seen while not converting starts a conversion.
//   The result is held on out_bcd/out_sign until the next conversion finishes.
//
// Ports
//   CLK        clock, all state on rising edge
//   reset      asynchronous active-high reset
//   in_valid   product valid (level); only its rising edge is acted on
//   in_product signed W-bit product, sampled on the accept edge
//   in_ready   high in IDLE or DONE (a new product may be accepted)
//   out_valid  high while out_bcd/out_sign hold a completed result
//   out_sign   1 = product was negative (never set for a zero product)
//   out_bcd    packed BCD magnitude, digit 0 (units) in bits [3:0]
//   busy       high while converting
module product_bcd_conv #(
    parameter int unsigned W      = 64,
    parameter int unsigned DIGITS = 20
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_product,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_sign,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              prev_valid_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              sign_q, sign_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sign_q, out_sign_d;
    logic [BcdW-1:0]   out_bcd_q, out_bcd_d;

    logic              accept;
    logic [BcdW-1:0]   bcd_adj;
    logic [BcdW-1:0]   bcd_sh;
    logic [W-1:0]      mag_sh;

    assign in_ready  = (state_q != StShift);
    assign busy      = (state_q == StShift);
    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_bcd   = out_bcd_q;

    // Rising edge of in_valid only; a held level starts exactly one conversion.
    assign accept = in_ready & in_valid & ~prev_valid_q;

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top BCD bit cannot be set given 10^DIGITS > 2^W, so it is dropped.
    assign {bcd_sh, mag_sh} = {bcd_adj[BcdW-2:0], mag_q, 1'b0};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_bcd_d   = out_bcd_q;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d     = StShift;
                    sign_d      = in_product[W-1];
                    // Most negative value negates to 2^(W-1), still valid unsigned.
                    mag_d       = in_product[W-1] ? (~in_product + W'(1)) : in_product;
                    bcd_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            StShift: begin
                bcd_d = bcd_sh;
                mag_d = mag_sh;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StDone;
                    out_bcd_d   = bcd_sh;
                    out_sign_d  = sign_q & (|bcd_sh);
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            prev_valid_q <= 1'b0;
            cnt_q        <= '0;
            mag_q        <= '0;
            bcd_q        <= '0;
            sign_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sign_q   <= 1'b0;
            out_bcd_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= in_valid;
            cnt_q        <= cnt_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            sign_q       <= sign_d;
            out_valid_q  <= out_valid_d;
            out_sign_q   <= out_sign_d;
            out_bcd_q    <= out_bcd_d;
        end
    end

endmodule

// File: tb/tb_product_bcd_conv.sv
module tb_product_bcd_conv;

    localparam int unsigned W      = 64;
    localparam int unsigned DIGITS = 20;

    logic                CLK;
    logic                reset;
    logic                in_valid;
    logic [W-1:0]        in_product;
    logic                in_ready;
    logic                out_valid;
    logic                out_sign;
    logic [4*DIGITS-1:0] out_bcd;
    logic                busy;

    product_bcd_conv #(
        .W      (W),
        .DIGITS (DIGITS)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_product (in_product),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_sign   (out_sign),
        .out_bcd    (out_bcd),
        .busy       (busy)
    );

    typedef struct {
        logic                sign;
        logic [4*DIGITS-1:0] bcd;
        int                  due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rising out_valid must match the oldest expected result.
    logic ov_prev = 1'b0;
    always @(negedge CLK) begin
        if (out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 128'(out_bcd), 128'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_sign", 128'(out_sign), 128'(e.sign));
                check("result_bcd", 128'(out_bcd), 128'(e.bcd));
                check("result_latency", 128'(cyc), 128'(e.due));
            end
        end
        ov_prev = out_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Raise in_valid with a product and queue the expected result.
    task automatic issue(input logic [W-1:0] p, input logic s, input logic [4*DIGITS-1:0] b);
        exp_t e;
        in_product = p;
        in_valid   = 1'b1;
        e.sign = s;
        e.bcd  = b;
        e.due  = cyc + 1 + int'(W);
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) step(1);
        if (sb.size() != 0) begin
            check("drain_timeout", 128'(sb.size()), 128'(0));
            sb.delete();
        end
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_sign", 128'(out_sign), 128'(0));
        check("rst_out_bcd", 128'(out_bcd), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        step(2);
        reset = 1'b0;
        step(1);

        // 2700 with level held well past completion: exactly one conversion.
        issue(64'd2700, 1'b0, 80'h2700);
        step(2);
        check("shift_busy", 128'(busy), 128'(1));
        check("shift_in_ready", 128'(in_ready), 128'(0));
        wait_drain();
        step(10);
        check("held_out_valid", 128'(out_valid), 128'(1));
        check("held_in_ready", 128'(in_ready), 128'(1));
        check("held_busy", 128'(busy), 128'(0));
        in_valid = 1'b0;
        step(2);

        // -2700
        issue(64'hFFFF_FFFF_FFFF_F574, 1'b1, 80'h2700);
        step(1);
        check("accept_out_valid_low", 128'(out_valid), 128'(0));
        in_valid = 1'b0;
        wait_drain();

        // zero: no negative zero
        issue(64'd0, 1'b0, 80'h0);
        step(2);
        in_valid = 1'b0;
        wait_drain();

        // most negative
        issue(64'h8000_0000_0000_0000, 1'b1, 80'h9223372036854775808);
        step(2);
        in_valid = 1'b0;
        wait_drain();

        // most positive
        issue(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 80'h9223372036854775807);
        step(2);
        in_valid = 1'b0;
        wait_drain();

        // in_valid pulse with 90 during SHIFT is ignored
        issue(64'd2700, 1'b0, 80'h2700);
        step(10);
        in_valid = 1'b0;
        step(1);
        in_valid   = 1'b1;
        in_product = 64'd90;
        check("pulse_in_ready", 128'(in_ready), 128'(0));
        step(1);
        check("pulse_busy", 128'(busy), 128'(1));
        wait_drain();
        in_valid = 1'b0;
        step(2);

        // Asynchronous reset mid-conversion
        issue(64'd2700, 1'b0, 80'h2700);
        step(30);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_out_bcd", 128'(out_bcd), 128'(0));
        check("midrst_out_sign", 128'(out_sign), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_busy", 128'(busy), 128'(0));
        in_valid = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        issue(64'hFFFF_FFFF_FFFF_FFA6, 1'b1, 80'h90);
        wait_drain();

        // Back-to-back: drop for one cycle in DONE, then re-accept with 90
        in_valid = 1'b0;
        step(1);
        issue(64'd90, 1'b0, 80'h90);
        step(1);
        check("b2b_out_valid_fall", 128'(out_valid), 128'(0));
        check("b2b_busy", 128'(busy), 128'(1));
        wait_drain();
        check("b2b_final_valid", 128'(out_valid), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/product_bcd_conv.md
Name: product_bcd_conv

Overview:
Sequential signed-binary to BCD converter that sits directly downstream of the 32x32 Booth multiplier. It consumes the 64-bit signed product and its level-held out_valid. It converts the magnitude to packed decimal digits using iterative double-dabble (shift-add-3), one bit per clock, and presents sign and digits to the display/report logic. A single conversion is in flight at a time, and the result is held stable until the next product is accepted.

Parameters:
W, 64, input product width in bits (two's complement)
DIGITS, 20, number of 4-bit BCD output digits; must satisfy 10^DIGITS > 2^W

Ports:
CLK  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  product-valid from the multiplier; level, may stay high many cycles
in_product  input  W  signed product, sampled on the accept edge only
in_ready  output  1  high when a new product can be accepted (state IDLE or DONE)
out_valid  output  1  high while out_bcd/out_sign hold a completed result
out_sign  output  1  1 = product was negative
out_bcd  output  4*DIGITS  packed BCD magnitude; digit 0 (units) in bits [3:0]
busy  output  1  high during SHIFT

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, out_sign=0, out_bcd=0, busy=0, in_ready=1, bit counter=0, internal shift regs=0, prev_valid=0. Reset takes effect without a clock edge.
- Accept condition: in_ready & in_valid & ~prev_valid, i.e. a rising edge of in_valid seen while not busy.
  - prev_valid is in_valid registered every cycle.
  - A level held high across many cycles triggers exactly one conversion.
  - A first-cycle-high after reset counts as a rising edge.
- States:
  - IDLE: wait for accept.
  - SHIFT: W iterations.
  - DONE: result held; accept allowed.
- IDLE/DONE -> SHIFT on accept edge E0:
  - latch sign = in_product[W-1].
  - latch magnitude = sign ? (~in_product + 1) : in_product, as a W-bit unsigned value. -2^(W-1) yields magnitude 2^(W-1), with no overflow.
  - clear BCD accumulator and counter.
  - out_valid -> 0; out_bcd/out_sign keep old values until the new result loads.
- SHIFT, each edge:
  - every BCD digit >= 5 gets +3.
  - {bcd, mag} shifts left 1.
  - counter increments.
- On edge E_W (the W-th SHIFT edge): state -> DONE.
  - out_bcd <= final accumulator, out_sign <= latched sign.
  - out_valid <= 1.
  - out_sign is forced 0 when magnitude is 0 (no negative zero).
- Latency: out_valid rises exactly W clock edges after the accept edge; 64 clocks at default.
- Throughput: one conversion per W+1 clocks minimum (accept at E_W+1 is legal since DONE asserts in_ready).
- During SHIFT: in_ready=0, busy=1. in_valid edges arriving then are ignored, not queued. prev_valid still tracks, so a level held through SHIFT does not retrigger at DONE.
- Reset mid-SHIFT: conversion aborted, all outputs cleared per reset list. The next rising edge of in_valid after reset release starts a fresh conversion.
- in_product is don't-care except on the accept edge.
- No digit overflow is possible given the DIGITS constraint. Upper unused digits read 0.

Test Plan:
- Reset, then in_product=2700 (30*90) with in_valid rising and held -> after 64 clocks out_valid=1, out_sign=0, out_bcd=...0002700 (digits 3..0 = 2,7,0,0; rest 0). Exactly one conversion occurs despite the held level.
- in_product=-2700 (0xFFFF_FFFF_FFFF_F574) -> out_sign=1, out_bcd digits = 2700; 0 -> out_sign=0, out_bcd all zero, out_valid after 64 clocks.
- Boundaries:
  - in_product=0x8000_0000_0000_0000 -> out_sign=1, out_bcd=9223372036854775808.
  - in_product=0x7FFF_FFFF_FFFF_FFFF -> out_sign=0, out_bcd=9223372036854775807.
- Pulse in_valid low-high at clock 10 of a conversion (value 90) -> ignored; in_ready=0 throughout SHIFT. The first result (2700) completes unchanged.
- Assert reset at clock 30 of a conversion, asynchronously between edges -> all outputs 0 and in_ready=1 immediately. A new rising in_valid with -90 gives out_sign=1, out_bcd=90 64 clocks later.
- Back-to-back: drop in_valid in DONE, raise it on the next cycle with 90 -> out_valid falls on the accept edge and rises 64 edges later with 90.
